// File: rtl/watch_pkg.sv
// Shared types and constants for the watch time controller: FSM states,
// button codes, field limits and reset date.
package watch_pkg;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_SET_YEAR  = 3'd1,
    ST_SET_MONTH = 3'd2,
    ST_SET_DAY   = 3'd3,
    ST_SET_HOUR  = 3'd4,
    ST_SET_MIN   = 3'd5
  } state_e;

  localparam logic [3:0] SW_MODE = 4'b0001;
  localparam logic [3:0] SW_EXIT = 4'b0010;
  localparam logic [3:0] SW_DEC  = 4'b0100;
  localparam logic [3:0] SW_INC  = 4'b1000;

  localparam logic [7:0] MONTH_MAX = 8'd12;
  localparam logic [7:0] HOUR_MAX  = 8'd23;
  localparam logic [7:0] MIN_MAX   = 8'd59;
  localparam logic [7:0] SEC_MAX   = 8'd59;
  localparam logic [2:0] WEEK_MAX  = 3'd6;

  localparam logic [11:0] YEAR_INIT_DEF = 12'd2020;
  localparam logic [2:0]  WEEK_INIT_DEF = 3'd3;
  localparam logic [7:0]  MONTH_INIT    = 8'd1;
  localparam logic [7:0]  DAY_INIT      = 8'd1;

endpackage

// File: rtl/watch_max_date.sv
// Combinational month length for a given year/month, including the
// Gregorian leap-year rule.
module watch_max_date
  import watch_pkg::*;
(
  input  logic [11:0] year,
  input  logic [7:0]  month,
  output logic [7:0]  max_date
);

  logic leap;

  assign leap = (year[1:0] == 2'b00) &&
                (((year % 12'd100) != 12'd0) || ((year % 12'd400) == 12'd0));

  always_comb begin
    max_date = 8'd31;
    case (month)
      8'd2:                       max_date = 8'd28 + {7'd0, leap};
      8'd4, 8'd6, 8'd9, 8'd11:    max_date = 8'd30;
      default:                    max_date = 8'd31;
    endcase
  end

endmodule

// File: rtl/watch_time_ctrl.sv
// Calendar/time-of-day keeper on a 1 Hz clock with a button-driven set mode.
// state: RUN counts time | SET_YEAR..SET_MIN edit one field, clock frozen.
module watch_time_ctrl
  import watch_pkg::*;
#(
  parameter logic [11:0] YEAR_INIT = YEAR_INIT_DEF,
  parameter logic [2:0]  WEEK_INIT = WEEK_INIT_DEF
) (
  input  logic        clk1sec,
  input  logic        rst,
  input  logic [3:0]  sw_in,
  output logic [11:0] year,
  output logic [7:0]  month,
  output logic [7:0]  day,
  output logic [7:0]  hour,
  output logic [7:0]  minute,
  output logic [7:0]  second,
  output logic [2:0]  week,
  output logic        set_mode,
  output logic [2:0]  set_field,
  output logic        day_tick
);

  state_e      state_q, state_d;
  logic [11:0] year_q, year_d, year_ed;
  logic [7:0]  month_q, month_d, month_ed;
  logic [7:0]  day_q, day_d, hour_q, hour_d, minute_q, minute_d, second_q, second_d;
  logic [2:0]  week_q, week_d, week_inc, week_dec;
  logic        day_tick_q, day_tick_d, set_mode_q, set_mode_d;
  logic [7:0]  max_cur, max_ed;

  assign week_inc = (week_q == WEEK_MAX) ? 3'd0 : week_q + 3'd1;
  assign week_dec = (week_q == 3'd0) ? WEEK_MAX : week_q - 3'd1;

  // Year/month after this cycle's edit, so the day clamp sees the new month length.
  always_comb begin
    year_ed  = year_q;
    month_ed = month_q;
    if (state_q == ST_SET_YEAR) begin
      if (sw_in == SW_INC)      year_ed = year_q + 12'd1;
      else if (sw_in == SW_DEC) year_ed = year_q - 12'd1;
    end
    if (state_q == ST_SET_MONTH) begin
      if (sw_in == SW_INC)      month_ed = (month_q == MONTH_MAX) ? 8'd1 : month_q + 8'd1;
      else if (sw_in == SW_DEC) month_ed = (month_q == 8'd1) ? MONTH_MAX : month_q - 8'd1;
    end
  end

  watch_max_date u_max_cur (.year(year_q),  .month(month_q),  .max_date(max_cur));
  watch_max_date u_max_ed  (.year(year_ed), .month(month_ed), .max_date(max_ed));

  always_comb begin
    state_d    = state_q;
    year_d     = year_q;
    month_d    = month_q;
    day_d      = day_q;
    hour_d     = hour_q;
    minute_d   = minute_q;
    second_d   = second_q;
    week_d     = week_q;
    day_tick_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (sw_in == SW_MODE) state_d = ST_SET_YEAR;
        if (second_q != SEC_MAX) second_d = second_q + 8'd1;
        else begin
          second_d = 8'd0;
          if (minute_q != MIN_MAX) minute_d = minute_q + 8'd1;
          else begin
            minute_d = 8'd0;
            if (hour_q != HOUR_MAX) hour_d = hour_q + 8'd1;
            else begin
              hour_d     = 8'd0;
              day_tick_d = 1'b1;
              week_d     = week_inc;
              if (day_q != max_cur) day_d = day_q + 8'd1;
              else begin
                day_d = 8'd1;
                if (month_q != MONTH_MAX) month_d = month_q + 8'd1;
                else begin
                  month_d = 8'd1;
                  year_d  = year_q + 12'd1;
                end
              end
            end
          end
        end
      end
      default: begin
        case (sw_in)
          SW_MODE: state_d = (state_q == ST_SET_MIN) ? ST_RUN : state_e'(state_q + 3'd1);
          SW_EXIT: begin
            state_d  = ST_RUN;
            second_d = 8'd0;
          end
          SW_INC, SW_DEC: begin
            year_d  = year_ed;
            month_d = month_ed;
            if ((state_q == ST_SET_YEAR || state_q == ST_SET_MONTH) && day_q > max_ed)
              day_d = max_ed;
            if (state_q == ST_SET_DAY) begin
              if (sw_in == SW_INC) begin
                day_d  = (day_q == max_cur) ? 8'd1 : day_q + 8'd1;
                week_d = week_inc;
              end else begin
                day_d  = (day_q == 8'd1) ? max_cur : day_q - 8'd1;
                week_d = week_dec;
              end
            end
            if (state_q == ST_SET_HOUR) begin
              if (sw_in == SW_INC) hour_d = (hour_q == HOUR_MAX) ? 8'd0 : hour_q + 8'd1;
              else                 hour_d = (hour_q == 8'd0) ? HOUR_MAX : hour_q - 8'd1;
            end
            if (state_q == ST_SET_MIN) begin
              if (sw_in == SW_INC) minute_d = (minute_q == MIN_MAX) ? 8'd0 : minute_q + 8'd1;
              else                 minute_d = (minute_q == 8'd0) ? MIN_MAX : minute_q - 8'd1;
            end
          end
          default: ;
        endcase
      end
    endcase
    set_mode_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk1sec or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      year_q     <= YEAR_INIT;
      month_q    <= MONTH_INIT;
      day_q      <= DAY_INIT;
      hour_q     <= 8'd0;
      minute_q   <= 8'd0;
      second_q   <= 8'd0;
      week_q     <= WEEK_INIT;
      day_tick_q <= 1'b0;
      set_mode_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      year_q     <= year_d;
      month_q    <= month_d;
      day_q      <= day_d;
      hour_q     <= hour_d;
      minute_q   <= minute_d;
      second_q   <= second_d;
      week_q     <= week_d;
      day_tick_q <= day_tick_d;
      set_mode_q <= set_mode_d;
    end
  end

  assign year      = year_q;
  assign month     = month_q;
  assign day       = day_q;
  assign hour      = hour_q;
  assign minute    = minute_q;
  assign second    = second_q;
  assign week      = week_q;
  assign set_mode  = set_mode_q;
  assign set_field = state_q;
  assign day_tick  = day_tick_q;

endmodule

// File: tb/tb_watch_time_ctrl.sv
// Self-checking bench for watch_time_ctrl: directed calendar corners plus
// random button traffic, compared every edge against a calendar model.
module tb_watch_time_ctrl;

  localparam logic [3:0] B_NOP  = 4'b0000;
  localparam logic [3:0] B_MODE = 4'b0001;
  localparam logic [3:0] B_EXIT = 4'b0010;
  localparam logic [3:0] B_DEC  = 4'b0100;
  localparam logic [3:0] B_INC  = 4'b1000;

  logic        clk1sec = 1'b0;
  logic        rst;
  logic [3:0]  sw_in;
  logic [11:0] year;
  logic [7:0]  month, day, hour, minute, second;
  logic [2:0]  week, set_field;
  logic        set_mode, day_tick;

  int n_chk  = 0;
  int n_pass = 0;

  int m_y, m_mo, m_d, m_h, m_mi, m_s, m_wk, m_fld, m_tick;
  int saved;

  watch_time_ctrl dut (
    .clk1sec(clk1sec), .rst(rst), .sw_in(sw_in),
    .year(year), .month(month), .day(day), .hour(hour), .minute(minute),
    .second(second), .week(week), .set_mode(set_mode), .set_field(set_field),
    .day_tick(day_tick)
  );

  always #5 clk1sec = ~clk1sec;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int dim(input int y, input int mo);
    int days [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    int lp;
    lp = ((y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0))) ? 1 : 0;
    return days[mo-1] + ((mo == 2) ? lp : 0);
  endfunction

  function automatic void model_reset();
    m_y = 2020; m_mo = 1; m_d = 1; m_h = 0; m_mi = 0; m_s = 0;
    m_wk = 3; m_fld = 0; m_tick = 0;
  endfunction

  function automatic void model_step(input logic [3:0] sw);
    int dlt, nd;
    m_tick = 0;
    dlt = (sw == B_INC) ? 1 : (sw == B_DEC) ? -1 : 0;
    if (m_fld == 0) begin
      m_s++;
      if (m_s == 60) begin
        m_s = 0; m_mi++;
        if (m_mi == 60) begin
          m_mi = 0; m_h++;
          if (m_h == 24) begin
            m_h = 0; m_tick = 1; m_wk = (m_wk + 1) % 7; m_d++;
            if (m_d > dim(m_y, m_mo)) begin
              m_d = 1; m_mo++;
              if (m_mo > 12) begin m_mo = 1; m_y = (m_y + 1) % 4096; end
            end
          end
        end
      end
      if (sw == B_MODE) m_fld = 1;
    end else if (sw == B_MODE) m_fld = (m_fld + 1) % 6;
    else if (sw == B_EXIT) begin m_fld = 0; m_s = 0; end
    else if (dlt != 0) begin
      case (m_fld)
        1: begin m_y = (m_y + dlt + 4096) % 4096; if (m_d > dim(m_y, m_mo)) m_d = dim(m_y, m_mo); end
        2: begin m_mo = (m_mo - 1 + dlt + 12) % 12 + 1; if (m_d > dim(m_y, m_mo)) m_d = dim(m_y, m_mo); end
        3: begin nd = dim(m_y, m_mo); m_d = (m_d - 1 + dlt + nd) % nd + 1; m_wk = (m_wk + dlt + 7) % 7; end
        4: m_h  = (m_h + dlt + 24) % 24;
        default: m_mi = (m_mi + dlt + 60) % 60;
      endcase
    end
  endfunction

  task automatic check_all();
    chk("year",      int'(year),      m_y);
    chk("month",     int'(month),     m_mo);
    chk("day",       int'(day),       m_d);
    chk("hour",      int'(hour),      m_h);
    chk("minute",    int'(minute),    m_mi);
    chk("second",    int'(second),    m_s);
    chk("week",      int'(week),      m_wk);
    chk("set_mode",  int'(set_mode),  (m_fld != 0) ? 1 : 0);
    chk("set_field", int'(set_field), m_fld);
    chk("day_tick",  int'(day_tick),  m_tick);
  endtask

  task automatic tick(input logic [3:0] sw);
    sw_in = sw;
    @(posedge clk1sec);
    model_step(sw);
    #1;
    check_all();
  endtask

  function automatic int model_field(input int fld);
    case (fld)
      1: return m_y;
      2: return m_mo;
      3: return m_d;
      4: return m_h;
      default: return m_mi;
    endcase
  endfunction

  // Step the currently selected field until it reaches target.
  task automatic dial(input int target);
    logic [3:0] dir;
    dir = (m_fld == 1 && target < m_y) ? B_DEC : B_INC;
    for (int n = 0; n < 4200 && model_field(m_fld) != target; n++) tick(dir);
  endtask

  // From RUN: set the full date and hh:mm, then EXIT so seconds restart at 0.
  task automatic set_datetime(input int y, input int mo, input int d, input int h, input int mi);
    tick(B_MODE); dial(y);
    tick(B_MODE); dial(mo);
    tick(B_MODE); dial(d);
    tick(B_MODE); dial(h);
    tick(B_MODE); dial(mi);
    tick(B_EXIT);
  endtask

  task automatic run_nop(input int n);
    for (int i = 0; i < n; i++) tick(B_NOP);
  endtask

  initial begin
    rst = 1'b0;
    sw_in = B_NOP;
    model_reset();
    #12;
    check_all();
    @(negedge clk1sec);
    rst = 1'b1;

    run_nop(61);
    chk("r61_year", int'(year), 2020);
    chk("r61_min", int'(minute), 1);
    chk("r61_sec", int'(second), 1);
    chk("r61_week", int'(week), 3);
    chk("r61_setmode", int'(set_mode), 0);

    set_datetime(2000, 2, 28, 23, 58);
    run_nop(119);
    chk("leap_pre_sec", int'(second), 59);
    saved = m_wk;
    tick(B_NOP);
    chk("leap2000_day", int'(day), 29);
    chk("leap2000_month", int'(month), 2);
    chk("leap2000_tick", int'(day_tick), 1);
    chk("leap2000_week", int'(week), (saved + 1) % 7);
    tick(B_NOP);
    chk("leap2000_tick_off", int'(day_tick), 0);

    set_datetime(2100, 2, 28, 23, 58);
    run_nop(120);
    chk("nl2100_day", int'(day), 1);
    chk("nl2100_month", int'(month), 3);

    set_datetime(4095, 12, 31, 23, 58);
    run_nop(119);
    saved = m_wk;
    tick(B_NOP);
    chk("wrap_year", int'(year), 0);
    chk("wrap_month", int'(month), 1);
    chk("wrap_day", int'(day), 1);
    chk("wrap_hour", int'(hour), 0);
    chk("wrap_week", int'(week), (saved + 1) % 7);

    tick(B_MODE); dial(2021);
    tick(B_MODE); dial(1);
    tick(B_MODE); dial(31);
    saved = m_wk;
    repeat (5) tick(B_MODE);
    chk("clamp_field", int'(set_field), 2);
    tick(B_INC);
    chk("clamp_month", int'(month), 2);
    chk("clamp_day", int'(day), 28);
    chk("clamp_week", int'(week), saved);

    tick(B_MODE); tick(B_MODE); dial(0);
    tick(B_DEC);
    chk("hour_dec_wrap", int'(hour), 23);
    tick(B_MODE); dial(59);
    tick(B_INC);
    chk("min_inc_wrap", int'(minute), 0);
    chk("min_inc_hour", int'(hour), 23);
    tick(B_EXIT);
    chk("exit_setmode", int'(set_mode), 0);
    chk("exit_sec", int'(second), 0);

    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: tick(B_NOP);
        4:          tick(B_MODE);
        5:          tick(B_EXIT);
        6, 9:       tick(B_INC);
        7:          tick(B_DEC);
        default:    tick(4'($urandom_range(0, 15)));
      endcase
    end

    tick(B_EXIT);
    repeat (3) tick(B_MODE);
    tick(B_INC); tick(B_INC);
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_set_field", int'(set_field), 0);
    @(negedge clk1sec);
    rst = 1'b1;
    run_nop(3);
    chk("post_rst_sec", int'(second), 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
